// File: rtl/int_ctrl_pri.sv
// int_ctrl_pri: N-source interrupt controller, two nesting priority levels.
// Build option INT_SYNC_EN adds a 2-flop synchroniser on src for async pins.
module int_ctrl_pri #(
    parameter int N_SRC = 5,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic [N_SRC-1:0] ie,
    input  logic             ea,
    input  logic [N_SRC-1:0] ip,
    input  logic [N_SRC-1:0] it,
    input  logic             int_ack,
    input  logic             reti,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] int_vec,
    output logic [N_SRC-1:0] pending,
    output logic [1:0]       in_svc
);

    logic [N_SRC-1:0] src_in;

`ifdef INT_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = src;
`endif

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] src_qq;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [1:0]       svc_q;
    logic [1:0]       svc_d;
    logic             req_q;
    logic             req_d;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  id_d;
    logic [N_SRC-1:0] vec_q;
    logic [N_SRC-1:0] vec_d;

    logic             ack_ok;
    logic             ack_lvl;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] hi;
    logic [N_SRC-1:0] lo;
    logic [N_SRC-1:0] cand;
    logic [ID_W-1:0]  win_id;

    assign ack_ok = int_ack & req_q;

    // A fresh edge beats the ack clear of the same source.
    always_comb begin
        ack_lvl = 1'b0;
        pend_d  = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (id_q == ID_W'(i)) begin
                ack_lvl = ip[i];
            end
            if (it[i]) begin
                pend_d[i] = (src_q[i] & ~src_qq[i])
                          | (pend_q[i] & ~(ack_ok && id_q == ID_W'(i)));
            end else begin
                pend_d[i] = src_q[i];
            end
        end
    end

    always_comb begin
        svc_d = svc_q;
        if (reti) begin
            if (svc_q[1]) begin
                svc_d[1] = 1'b0;
            end else begin
                svc_d[0] = 1'b0;
            end
        end
        if (ack_ok) begin
            if (ack_lvl) begin
                svc_d[1] = 1'b1;
            end else begin
                svc_d[0] = 1'b1;
            end
        end
    end

    assign elig = pend_q & ie & {N_SRC{ea}};
    assign hi   = elig & ip & {N_SRC{~svc_q[1]}};
    assign lo   = elig & ~ip & {N_SRC{svc_q == 2'b00}};
    assign cand = (|hi) ? hi : lo;

    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    assign req_d = (|cand) & ~ack_ok;
    assign id_d  = req_d ? win_id : id_q;
    assign vec_d = ack_ok ? '0 : (cand & (~cand + N_SRC'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            src_qq <= '0;
            pend_q <= '0;
            svc_q  <= '0;
            req_q  <= 1'b0;
            id_q   <= '0;
            vec_q  <= '0;
        end else begin
            src_q  <= src_in;
            src_qq <= src_q;
            pend_q <= pend_d;
            svc_q  <= svc_d;
            req_q  <= req_d;
            id_q   <= id_d;
            vec_q  <= vec_d;
        end
    end

    assign int_req = req_q;
    assign int_id  = id_q;
    assign int_vec = vec_q;
    assign pending = pend_q;
    assign in_svc  = svc_q;

endmodule
